uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. It supports configurable data width, parity and stop-bit count, and takes each bit by 3-sample majority vote. It reports parity, framing, overrun and break conditions. Received words are held behind a valid/ready handshake, so the consumer (FIFO, command decoder) may stall without losing the current word.

Parameters:
CLK_FREQ, 24_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; CYC_PER_BIT = CLK_FREQ/BAUD_RATE, HALF = CYC_PER_BIT/2
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
Elaboration error if CYC_PER_BIT < 8, DATA_BITS is out of range, PARITY > 2, or STOP_BITS is not in {1,2}.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous active-low
rx  in  1  asynchronous serial line, idle high
data_out  out  DATA_BITS  received word, LSB = first data bit
data_valid  out  1  data_out is held and valid
data_ready  in  1  consumer accepts the word when data_valid && data_ready
parity_err  out  1  parity mismatch for the word in data_out; valid while data_valid
frame_err  out  1  a stop bit was sampled 0 for the word in data_out; valid while data_valid
overrun  out  1  one-cycle pulse: a completed frame was dropped because data_valid was still set
break_det  out  1  one-cycle pulse: break condition detected

Behaviour:
- Reset, applied on a clk edge while rst_n = 0:
  - state = IDLE; sync flops = 1; counters = 0.
  - data_out = 0; data_valid, parity_err, frame_err, overrun and break_det = 0.
  - Reset mid-frame aborts the frame and discards the partial word.
- Synchroniser: 2-flop, reset value 1; rxs denotes the synchronised line.
- Bit timing: per-bit counter cnt runs 0..CYC_PER_BIT-1 and wraps; counter width is $clog2(CYC_PER_BIT).
  - rxs is sampled at cnt = HALF-1, HALF and HALF+1.
  - The bit value is the majority of the 3 samples, decided at cnt = HALF+1.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: cnt = 0; rxs = 0 -> START, with cnt beginning at 1 on the next cycle.
  - START: at decision, bit = 1 -> IDLE (glitch rejected, nothing reported); bit = 0 -> continue. At cnt wrap -> DATA.
  - DATA: shifts in DATA_BITS bits LSB first. After the last bit's wrap -> PARITY if PARITY != 0, else STOP.
  - PARITY: sample the parity bit; perr = (XOR of data bits ^ parity bit) != (PARITY==1 ? 1 : 0). At wrap -> STOP.
  - STOP: STOP_BITS bit periods; ferr is set if any stop bit decides 0.
    - At the decision of the last stop bit the frame completes and the state goes straight to IDLE (mid-bit), with no wait for wrap. This gives resync margin.
  - Break: all data bits 0, parity bit 0 (if present) and the first stop bit 0.
    - At that stop decision: break_det pulses for 1 cycle, no word is delivered, and the state goes to BRK_WAIT.
    - BRK_WAIT: stays until rxs = 1, then -> IDLE.
- Delivery, registered 1 cycle after the completing decision:
  - If data_valid = 0, or data_valid && data_ready in that same cycle: load data_out, parity_err and frame_err; data_valid = 1.
  - Otherwise: the new frame is dropped, data_out and flags are unchanged, and overrun pulses for 1 cycle.
- data_valid clears on the cycle after a handshake unless a new load occurs in that same cycle. A new load wins, with no overrun.
- If DATA_BITS = 9, parity is computed over all 9 bits.
- Outputs are registered; there are no combinational paths from rx or data_ready to outputs.

Decomposition:
- Package uart_pkg holds:
  - Parity encodings: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - The rx state localparams.
  - A function computing CYC_PER_BIT from CLK_FREQ and BAUD_RATE.
- Sub-module uart_rx_sampler contains the 2-flop synchroniser and the 3-sample majority voter (inputs cnt and rx; outputs rxs and bit_val). The FSM, shift register and handshake stay in uart_rx_ext.

Test Plan:
All cases use CLK_FREQ 24e6 and BAUD 115200 (CYC = 208, HALF = 104).
1. 8N1, data_ready = 1, send 0xA5 -> data_valid 1 cycle, data_out = 0xA5, parity_err = 0, frame_err = 0; first assertion 1 cycle after stop decision (~9.5 bit times after start edge).
2. PARITY = 2, send 0x37 with parity bit 1 -> parity_err = 0; resend 0x37 with parity bit 0 -> data_out = 0x37, parity_err = 1.
3. rx low for 50 cycles then high -> no data_valid, FSM back in IDLE; next 0x5A frame is received correctly. A 1-cycle low glitch at a data bit's cnt = HALF is ignored by the majority vote.
4. Send 0x55 with stop bit = 0 (rx high during the following idle) -> data_out = 0x55, frame_err = 1, break_det = 0.
5. data_ready = 0, send 0x11 then 0x22 -> data_out stays 0x11, overrun pulses once. Then raise data_ready -> 0x11 accepted, data_valid = 0.
6. Hold rx low for 12 bit times, then high -> break_det pulses exactly once, no data_valid. A following 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the extended UART receiver: parity encodings,
// receiver state encoding and bit-timing helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    function automatic int cyc_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus 3-sample majority voter around the bit centre.
// bit_val is meaningful on the cycle where cnt equals HALF+1.
module uart_rx_sampler #(
    parameter int CNT_W = 8,
    parameter int HALF  = 104
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic [CNT_W-1:0] cnt,
    output logic             rxs,
    output logic             bit_val
);

    localparam logic [CNT_W-1:0] CNT_S0 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1 = CNT_W'(HALF);

    logic rx_meta;
    logic samp0;
    logic samp1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            samp0   <= 1'b1;
            samp1   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            if (cnt == CNT_S0)
                samp0 <= rxs;
            if (cnt == CNT_S1)
                samp1 <= rxs;
        end
    end

    // Third vote is the live synchronised line at cnt = HALF+1
    assign bit_val = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with parity/framing/overrun/break reporting
// and a valid/ready output holding register.
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 24_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CYC_PER_BIT = cyc_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF        = CYC_PER_BIT / 2;
    localparam int CNT_W       = $clog2(CYC_PER_BIT);
    localparam int IDX_W       = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CYC_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(HALF + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (CYC_PER_BIT < 8) begin : g_bad_baud
        $error("uart_rx_ext: CLK_FREQ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_ext: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_ext: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_ext: STOP_BITS must be 1 or 2");
    end

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 frame_done;
    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_perr;
    logic                 frame_ferr;
    logic                 rxs;
    logic                 bit_val;
    logic                 decide;
    logic                 wrap;

    uart_rx_sampler #(
        .CNT_W (CNT_W),
        .HALF  (HALF)
    ) u_sampler (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .cnt     (cnt),
        .rxs     (rxs),
        .bit_val (bit_val)
    );

    assign decide = (cnt == CNT_DEC);
    assign wrap   = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            ferr_acc   <= 1'b0;
            frame_done <= 1'b0;
            frame_data <= '0;
            frame_perr <= 1'b0;
            frame_ferr <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            break_det  <= 1'b0;
            if (state != ST_IDLE && state != ST_BRK_WAIT)
                cnt <= wrap ? '0 : cnt + CNT_W'(1);

            unique case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    ferr_acc <= 1'b0;
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_START: begin
                    if (decide && bit_val) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide)
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (wrap) begin
                        if (bit_idx == IDX_LAST)
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        else
                            bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (decide)
                        par_bit <= bit_val;
                    if (wrap)
                        state <= ST_STOP;
                end
                ST_STOP: begin
                    // Frame ends at the last stop decision, not the wrap, to regain resync margin
                    if (decide) begin
                        if (stop_idx == 1'b0 && !bit_val && shreg == '0 &&
                            (PARITY == PAR_NONE || !par_bit)) begin
                            break_det <= 1'b1;
                            state     <= ST_BRK_WAIT;
                            cnt       <= '0;
                        end else if (stop_idx == STOP_LAST) begin
                            frame_done <= 1'b1;
                            frame_data <= shreg;
                            frame_perr <= (PARITY != PAR_NONE) &&
                                          ((^shreg ^ par_bit) != (PARITY == PAR_ODD));
                            frame_ferr <= ferr_acc | ~bit_val;
                            state      <= ST_IDLE;
                            cnt        <= '0;
                        end else begin
                            ferr_acc <= ferr_acc | ~bit_val;
                        end
                    end else if (wrap) begin
                        stop_idx <= stop_idx + 1'b1;
                    end
                end
                ST_BRK_WAIT: begin
                    cnt <= '0;
                    if (rxs)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A load in the same cycle as a handshake wins and keeps data_valid high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done && (!data_valid || data_ready)) begin
                data_out   <= frame_data;
                parity_err <= frame_perr;
                frame_err  <= frame_ferr;
                data_valid <= 1'b1;
            end else begin
                if (frame_done)
                    overrun <= 1'b1;
                if (data_valid && data_ready)
                    data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: an 8N1 instance and an 8E1 instance
// driven by hand-built frames, each checked against hand-computed values.
module tb_uart_rx_ext;

    localparam int CYC = 208;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       data_ready = 1'b1;
    logic       data_ready_p = 1'b1;
    logic [7:0] data_out, data_out_p;
    logic       data_valid, data_valid_p;
    logic       parity_err, parity_err_p;
    logic       frame_err, frame_err_p;
    logic       overrun, overrun_p;
    logic       break_det, break_det_p;

    int tests_run = 0;
    int failures  = 0;
    int cyc = 0;
    int start_cyc = 0;

    int hs_cnt = 0, valid_cycles = 0, ovr_cnt = 0, brk_cnt = 0, first_valid_cyc = 0;
    logic [7:0] hs_data = 8'h00;
    logic hs_perr = 1'b0, hs_ferr = 1'b0, valid_q = 1'b0;
    int hs_cnt_p = 0;
    logic [7:0] hs_data_p = 8'h00;
    logic hs_perr_p = 1'b0;

    int hs0, vc0, ov0, br0;

    uart_rx_ext #(
        .CLK_FREQ (24_000_000), .BAUD_RATE (115200),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .break_det(break_det)
    );

    uart_rx_ext #(
        .CLK_FREQ (24_000_000), .BAUD_RATE (115200),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_par (
        .clk(clk), .rst_n(rst_n), .rx(rx_p),
        .data_out(data_out_p), .data_valid(data_valid_p), .data_ready(data_ready_p),
        .parity_err(parity_err_p), .frame_err(frame_err_p),
        .overrun(overrun_p), .break_det(break_det_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Output pulses are short, so they are captured on every falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid && data_ready) begin
                hs_cnt  = hs_cnt + 1;
                hs_data = data_out;
                hs_perr = parity_err;
                hs_ferr = frame_err;
            end
            if (data_valid) valid_cycles = valid_cycles + 1;
            if (data_valid && !valid_q) first_valid_cyc = cyc;
            valid_q = data_valid;
            if (overrun) ovr_cnt = ovr_cnt + 1;
            if (break_det) brk_cnt = brk_cnt + 1;
            if (data_valid_p && data_ready_p) begin
                hs_cnt_p  = hs_cnt_p + 1;
                hs_data_p = data_out_p;
                hs_perr_p = parity_err_p;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int line, input logic v);
        if (line == 0) rx = v;
        else rx_p = v;
    endtask

    // par_bit < 0 means no parity bit; glitch_bit >= 0 pulls that data bit low for one cycle mid-bit
    task automatic applyStimulus(input int line, input logic [7:0] data, input int par_bit,
                                 input logic stop_val, input int glitch_bit);
        logic [10:0] frame;
        int nb;
        logic v;
        frame = '1;
        frame[0] = 1'b0;
        frame[8:1] = data;
        nb = 9;
        if (par_bit >= 0) begin
            frame[9] = par_bit[0];
            nb = 10;
        end
        frame[nb] = stop_val;
        nb = nb + 1;
        start_cyc = cyc;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < CYC; i++) begin
                v = frame[b];
                if (glitch_bit >= 0 && b == glitch_bit + 1 && i == CYC / 2) v = 1'b0;
                set_line(line, v);
                idle(1);
            end
        end
        set_line(line, 1'b1);
    endtask

    task automatic snap;
        hs0 = hs_cnt;
        vc0 = valid_cycles;
        ov0 = ovr_cnt;
        br0 = brk_cnt;
    endtask

    initial begin
        idle(5);
        checkOutput("reset data_valid", 32'(data_valid), 0);
        checkOutput("reset data_out", 32'(data_out), 0);
        checkOutput("reset flags", {28'd0, parity_err, frame_err, overrun, break_det}, 0);
        checkOutput("reset par data_valid", 32'(data_valid_p), 0);
        rst_n = 1'b1;
        idle(10);

        // 8N1 word 0xA5 with latency check
        snap();
        applyStimulus(0, 8'hA5, -1, 1'b1, -1);
        idle(20);
        checkOutput("t1 words", 32'(hs_cnt - hs0), 1);
        checkOutput("t1 data", 32'(hs_data), 32'hA5);
        checkOutput("t1 perr/ferr", {30'd0, hs_perr, hs_ferr}, 0);
        checkOutput("t1 valid cycles", 32'(valid_cycles - vc0), 1);
        checkOutput("t1 latency", 32'(first_valid_cyc - start_cyc), 1981);
        checkOutput("t1 valid after", 32'(data_valid), 0);

        // Even parity: 0x37 has five ones, so parity bit 1 is correct
        applyStimulus(1, 8'h37, 1, 1'b1, -1);
        idle(20);
        checkOutput("t2 good data", 32'(hs_data_p), 32'h37);
        checkOutput("t2 good perr", 32'(hs_perr_p), 0);
        applyStimulus(1, 8'h37, 0, 1'b1, -1);
        idle(20);
        checkOutput("t2 bad data", 32'(hs_data_p), 32'h37);
        checkOutput("t2 bad perr", 32'(hs_perr_p), 1);
        checkOutput("t2 words", 32'(hs_cnt_p), 2);

        // Short start pulse rejected, then a glitched frame still decoded
        snap();
        rx = 1'b0;
        idle(50);
        rx = 1'b1;
        idle(300);
        checkOutput("t3 no word", 32'(valid_cycles - vc0), 0);
        applyStimulus(0, 8'h5A, -1, 1'b1, 1);
        idle(20);
        checkOutput("t3 words", 32'(hs_cnt - hs0), 1);
        checkOutput("t3 data", 32'(hs_data), 32'h5A);
        checkOutput("t3 ferr", 32'(hs_ferr), 0);

        // Stop bit low on a non-zero word: framing error, not a break
        snap();
        applyStimulus(0, 8'h55, -1, 1'b0, -1);
        idle(300);
        checkOutput("t4 data", 32'(hs_data), 32'h55);
        checkOutput("t4 ferr", 32'(hs_ferr), 1);
        checkOutput("t4 break", 32'(brk_cnt - br0), 0);
        checkOutput("t4 words", 32'(hs_cnt - hs0), 1);

        // Stalled consumer: second word dropped with a single overrun
        snap();
        data_ready = 1'b0;
        applyStimulus(0, 8'h11, -1, 1'b1, -1);
        applyStimulus(0, 8'h22, -1, 1'b1, -1);
        idle(20);
        checkOutput("t5 held data", 32'(data_out), 32'h11);
        checkOutput("t5 held valid", 32'(data_valid), 1);
        checkOutput("t5 overrun", 32'(ovr_cnt - ov0), 1);
        data_ready = 1'b1;
        idle(3);
        checkOutput("t5 accepted", 32'(hs_data), 32'h11);
        checkOutput("t5 valid clear", 32'(data_valid), 0);

        // Long low line: one break pulse, no word, then normal reception
        snap();
        rx = 1'b0;
        idle(12 * CYC);
        rx = 1'b1;
        idle(300);
        checkOutput("t6 break", 32'(brk_cnt - br0), 1);
        checkOutput("t6 no word", 32'(valid_cycles - vc0), 0);
        applyStimulus(0, 8'h3C, -1, 1'b1, -1);
        idle(20);
        checkOutput("t6 data", 32'(hs_data), 32'h3C);
        checkOutput("t6 words", 32'(hs_cnt - hs0), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
